// File: rtl/note_sequencer.sv
// Pattern sequencer feeding clock_scale: steps through stored note periods at a
// programmable tempo and drives a gate that mutes rests and an end-of-step gap.
module note_sequencer #(
  parameter  int STEPS   = 8,
  parameter  int PW      = 11,
  parameter  int TEMPO_W = 16,
  localparam int AW      = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PW-1:0]      wr_data,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic [7:0]         gap,
  input  logic [AW-1:0]      length,
  input  logic               loop_en,
  input  logic               start,
  input  logic               stop,
  output logic [PW-1:0]      scale_factor,
  output logic               gate,
  output logic [AW-1:0]      step_idx,
  output logic               step_strobe,
  output logic               busy
);

  // state | meaning
  // IDLE  | not playing; all outputs held at 0
  // PLAY  | stepping through pat[0..length]
  typedef enum logic {IDLE, PLAY} state_t;

  state_t              state, state_next;
  logic [PW-1:0]       pat [STEPS];
  logic [TEMPO_W-1:0]  tcnt;
  logic                enter_step;
  logic [AW-1:0]       next_idx;
  logic                step_done;
  logic                at_end;
  logic [TEMPO_W:0]    gate_sum;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // >= rather than == keeps the step bounded if tempo/length drop mid-step
  assign step_done = (tcnt >= tempo);
  assign at_end    = (step_idx >= length);

  always_comb begin
    state_next = state;
    enter_step = 1'b0;
    next_idx   = step_idx;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_next = PLAY;
          enter_step = 1'b1;
          next_idx   = '0;
        end
      end
      PLAY: begin
        if (stop) begin
          state_next = IDLE;
        end else if (start) begin
          enter_step = 1'b1;
          next_idx   = '0;
        end else if (step_done) begin
          if (!at_end) begin
            enter_step = 1'b1;
            next_idx   = step_idx + AW'(1);
          end else if (loop_en) begin
            enter_step = 1'b1;
            next_idx   = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The step latch reads pat before a same-cycle write lands, so old data wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt         <= '0;
      step_idx     <= '0;
      scale_factor <= '0;
      step_strobe  <= 1'b0;
      for (int i = 0; i < STEPS; i++) pat[i] <= '0;
    end else begin
      if (wr_en) pat[wr_addr] <= wr_data;
      step_strobe <= enter_step;
      if (enter_step) begin
        step_idx     <= next_idx;
        scale_factor <= pat[next_idx];
        tcnt         <= '0;
      end else if (state_next == IDLE) begin
        step_idx     <= '0;
        scale_factor <= '0;
        tcnt         <= '0;
      end else begin
        tcnt <= tcnt + TEMPO_W'(1);
      end
    end
  end

  // One extra bit so tcnt + gap cannot wrap past tempo.
  assign gate_sum = {1'b0, tcnt} + (TEMPO_W+1)'(gap);

  always_comb begin
    busy = (state == PLAY);
    gate = busy && (scale_factor != '0) && (gate_sum <= {1'b0, tempo});
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed table, hand sequences for multi-cycle
// corners, and random traffic against a step-level reference model.
module tb_note_sequencer;

  typedef struct {
    logic        rst, wr_en;
    logic [2:0]  wr_addr;
    logic [10:0] wr_data;
    logic [15:0] tempo;
    logic [7:0]  gap;
    logic [2:0]  length;
    logic        loop_en, start, stop;
  } in_t;

  typedef struct {
    in_t         i;
    logic [10:0] sf;
    logic        gate;
    logic [2:0]  idx;
    logic        strobe, busy;
  } vec_t;

  logic        clk = 0;
  logic        rst, wr_en, loop_en, start, stop;
  logic [2:0]  wr_addr, length;
  logic [10:0] wr_data;
  logic [15:0] tempo;
  logic [7:0]  gap;
  logic [10:0] scale_factor;
  logic        gate, step_strobe, busy;
  logic [2:0]  step_idx;

  int vectors = 0;
  int miscompares = 0;

  in_t cur;

  // reference model: playback position tracked as plain integers
  bit m_play;
  int m_idx, m_cnt, m_note;
  bit m_strobe;
  int m_pat [8];

  always #5 clk = ~clk;

  note_sequencer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .tempo(tempo), .gap(gap), .length(length), .loop_en(loop_en),
    .start(start), .stop(stop), .scale_factor(scale_factor), .gate(gate),
    .step_idx(step_idx), .step_strobe(step_strobe), .busy(busy)
  );

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(in_t x);
    bit enter;
    int nidx;
    if (x.rst) begin
      m_play = 0; m_idx = 0; m_cnt = 0; m_note = 0; m_strobe = 0;
      foreach (m_pat[k]) m_pat[k] = 0;
      return;
    end
    enter = 0;
    nidx = 0;
    if (x.stop) m_play = 0;
    else if (x.start) begin m_play = 1; enter = 1; nidx = 0; end
    else if (m_play) begin
      if (m_cnt >= int'(x.tempo)) begin
        if (m_idx < int'(x.length)) begin enter = 1; nidx = m_idx + 1; end
        else if (x.loop_en) begin enter = 1; nidx = 0; end
        else m_play = 0;
      end else m_cnt++;
    end
    m_strobe = enter;
    if (enter) begin m_idx = nidx; m_note = m_pat[nidx]; m_cnt = 0; end
    if (!m_play) begin m_idx = 0; m_note = 0; m_cnt = 0; end
    if (x.wr_en) m_pat[x.wr_addr] = int'(x.wr_data);
  endtask

  function automatic int model_gate(in_t x);
    return (m_play && m_note != 0 && (m_cnt + int'(x.gap) <= int'(x.tempo))) ? 1 : 0;
  endfunction

  task automatic tick();
    rst = cur.rst; wr_en = cur.wr_en; wr_addr = cur.wr_addr; wr_data = cur.wr_data;
    tempo = cur.tempo; gap = cur.gap; length = cur.length; loop_en = cur.loop_en;
    start = cur.start; stop = cur.stop;
    @(posedge clk);
    model_update(cur);
    #1;
    chk("scale_factor", int'(scale_factor), m_note);
    chk("gate", int'(gate), model_gate(cur));
    chk("step_idx", int'(step_idx), m_idx);
    chk("step_strobe", int'(step_strobe), int'(m_strobe));
    chk("busy", int'(busy), int'(m_play));
    cur.rst = 0; cur.start = 0; cur.stop = 0; cur.wr_en = 0;
  endtask

  function automatic vec_t mk(bit r, bit we, int wa, int wd, int tp, int gp, int ln, bit lp,
                              bit st, bit sp, int sf, bit g, int idx, bit sb, bit bz);
    vec_t v;
    v.i.rst = r; v.i.wr_en = we; v.i.wr_addr = 3'(wa); v.i.wr_data = 11'(wd);
    v.i.tempo = 16'(tp); v.i.gap = 8'(gp); v.i.length = 3'(ln); v.i.loop_en = lp;
    v.i.start = st; v.i.stop = sp;
    v.sf = 11'(sf); v.gate = g; v.idx = 3'(idx); v.strobe = sb; v.busy = bz;
    return v;
  endfunction

  task automatic set_cfg(int tp, int gp, int ln, bit lp);
    cur.tempo = 16'(tp); cur.gap = 8'(gp); cur.length = 3'(ln); cur.loop_en = lp;
  endtask

  task automatic wr(int a, int d);
    cur.wr_en = 1; cur.wr_addr = 3'(a); cur.wr_data = 11'(d);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [11];
    int strobes, gates, guard;

    //          rst we wa wd  tp gp ln lp st sp   sf  g idx sb bz
    tbl[0]  = mk(1, 0, 0, 0,   1, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 100, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 0,   1, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0,   1, 1, 1, 0, 1, 0, 100, 1, 0, 1, 1);
    tbl[4]  = mk(0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 100, 0, 0, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0,   1, 1, 1, 0, 0, 0,   0, 0, 1, 1, 1);
    tbl[6]  = mk(0, 0, 0, 0,   1, 1, 1, 0, 0, 0,   0, 0, 1, 0, 1);
    tbl[7]  = mk(0, 0, 0, 0,   1, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0,   1, 1, 1, 0, 1, 1,   0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0,   1, 0, 1, 0, 1, 0, 100, 1, 0, 1, 1);
    tbl[10] = mk(0, 0, 0, 0,   1, 0, 1, 0, 0, 1,   0, 0, 0, 0, 0);

    cur = tbl[0].i;
    for (int n = 0; n < 11; n++) begin
      cur = tbl[n].i;
      tick();
      chk("tbl_sf", int'(scale_factor), int'(tbl[n].sf));
      chk("tbl_gate", int'(gate), int'(tbl[n].gate));
      chk("tbl_idx", int'(step_idx), int'(tbl[n].idx));
      chk("tbl_strobe", int'(step_strobe), int'(tbl[n].strobe));
      chk("tbl_busy", int'(busy), int'(tbl[n].busy));
    end

    // one-shot pass over four steps with an articulation gap
    cur.rst = 1; tick();
    wr(0, 100); wr(1, 0); wr(2, 250); wr(3, 2047);
    set_cfg(9, 2, 3, 0);
    cur.start = 1;
    strobes = 0; gates = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      strobes += int'(step_strobe);
      gates += int'(gate);
      if (k == 10) chk("t1_rest_sf", int'(scale_factor), 0);
      if (k == 30) chk("t1_sf3", int'(scale_factor), 2047);
    end
    chk("t1_strobes", strobes, 4);
    chk("t1_gate_cycles", gates, 24);
    tick();
    chk("t1_idle_busy", int'(busy), 0);

    // looping single-cycle steps
    set_cfg(0, 0, 3, 1);
    cur.start = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("t2_idx", int'(step_idx), k % 4);
      chk("t2_strobe", int'(step_strobe), 1);
      chk("t2_gate", int'(gate), (k % 4 != 1) ? 1 : 0);
    end
    cur.stop = 1; tick();

    // restart mid-play, then start+stop together
    set_cfg(9, 2, 3, 1);
    cur.start = 1; tick();
    guard = 0;
    while (step_idx != 3'd2 && guard < 100) begin tick(); guard++; end
    chk("t3_reach_step2", (guard < 100) ? 1 : 0, 1);
    tick();
    cur.start = 1; tick();
    chk("t3_restart_idx", int'(step_idx), 0);
    chk("t3_restart_strobe", int'(step_strobe), 1);
    cur.start = 1; cur.stop = 1; tick();
    chk("t3_startstop_busy", int'(busy), 0);

    // write to pat[2] in the same cycle step 2 is latched
    set_cfg(3, 0, 3, 1);
    cur.start = 1; tick();
    guard = 0;
    while (!(step_strobe && step_idx == 3'd1) && guard < 50) begin tick(); guard++; end
    chk("t4_reach_step1", (guard < 50) ? 1 : 0, 1);
    tick(); tick(); tick();
    wr(2, 500);
    chk("t4_idx2", int'(step_idx), 2);
    chk("t4_old_data", int'(scale_factor), 250);
    tick();
    guard = 0;
    while (!(step_strobe && step_idx == 3'd2) && guard < 50) begin tick(); guard++; end
    chk("t4_new_data", int'(scale_factor), 500);

    // gap larger than tempo: gate never opens
    cur.stop = 1; tick();
    set_cfg(9, 20, 3, 0);
    cur.start = 1;
    strobes = 0; gates = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      strobes += int'(step_strobe);
      gates += int'(gate);
    end
    chk("t5_strobes", strobes, 4);
    chk("t5_gate_cycles", gates, 0);

    // reset mid-step wipes outputs and pattern
    set_cfg(9, 0, 3, 1);
    cur.start = 1; tick(); tick(); tick();
    cur.rst = 1; tick();
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_sf", int'(scale_factor), 0);
    cur.start = 1; tick();
    chk("t5_pat_cleared", int'(scale_factor), 0);

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      cur.rst = ($urandom_range(0, 299) == 0);
      cur.start = ($urandom_range(0, 19) == 0);
      cur.stop = ($urandom_range(0, 49) == 0);
      cur.wr_en = ($urandom_range(0, 3) == 0);
      cur.wr_addr = 3'($urandom_range(0, 7));
      cur.wr_data = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
      if ($urandom_range(0, 29) == 0) cur.tempo = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 29) == 0) cur.gap = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) cur.length = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) cur.loop_en = 1'($urandom_range(0, 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
